nrf24_tx_req_scheduler: RTL



---
 rtl/nrf24_tx_req_scheduler_if.sv | 26 ++
 rtl/nrf24_tx_req_scheduler.sv | 109 ++++++++++
 2 files changed

// File: rtl/nrf24_tx_req_scheduler_if.sv
// nrf24_tx_req_scheduler_if: status inputs and TX request handshake between board, scheduler and NRF24 controller
interface nrf24_tx_req_scheduler_if #(
    parameter int N_CH      = 4,
    parameter int PAYLOAD_W = 8
);
    localparam int SEQ_W = PAYLOAD_W - N_CH;

    logic [N_CH-1:0]      cap_in;
    logic                 enable;
    logic                 tx_done;
    logic                 tx_req;
    logic [PAYLOAD_W-1:0] tx_data;
    logic                 busy;
    logic                 tx_timeout;
    logic [SEQ_W-1:0]     seq;

    modport master (
        output cap_in, enable, tx_done,
        input  tx_req, tx_data, busy, tx_timeout, seq
    );

    modport slave (
        input  cap_in, enable, tx_done,
        output tx_req, tx_data, busy, tx_timeout, seq
    );
endinterface

// File: rtl/nrf24_tx_req_scheduler.sv
// nrf24_tx_req_scheduler: turns changes on synchronised status inputs into sequence-tagged NRF24 TX requests
module nrf24_tx_req_scheduler #(
    parameter int N_CH           = 4,
    parameter int PAYLOAD_W      = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 2000,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    nrf24_tx_req_scheduler_if.slave bus
);
    localparam int SEQ_W   = PAYLOAD_W - N_CH;
    localparam int CNT_MAX = TIMEOUT_CYCLES > HOLD_CYCLES ? TIMEOUT_CYCLES : HOLD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TLAST   = TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0;
    // the tx_done/timeout cycle is the first hold clock, so HOLDOFF itself lasts HOLD_CYCLES-1 (min 1)
    localparam int HLAST   = HOLD_CYCLES > 1 ? HOLD_CYCLES - 2 : 0;
    localparam int RW      = REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;
    localparam int RLAST   = REFRESH_CYCLES > 0 ? REFRESH_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE, HOLDOFF} state_t;

    state_t                           state, state_n;
    logic [SYNC_STAGES-1:0][N_CH-1:0] sync;
    logic [N_CH-1:0]                  cap_s;
    logic [N_CH-1:0]                  last_sent;
    logic                             pending;
    logic                             launch;
    logic                             timeout;
    logic                             ref_sat;
    logic                             refresh_due;
    logic [CW-1:0]                    cnt;
    logic [RW-1:0]                    ref_cnt;
    logic [SEQ_W-1:0]                 seq;
    logic [PAYLOAD_W-1:0]             tx_data;

    assign cap_s          = sync[SYNC_STAGES-1];
    assign ref_sat        = ref_cnt == RW'(RLAST);
    assign refresh_due    = (REFRESH_CYCLES != 0) && ref_sat;
    assign bus.tx_req     = state == REQ;
    assign bus.busy       = state != IDLE;
    assign bus.tx_timeout = timeout;
    assign bus.tx_data    = tx_data;
    assign bus.seq        = seq;

    // next state; launch and timeout are single-cycle strobes derived here
    always_comb begin
        state_n = state;
        launch  = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE: begin
                launch  = bus.enable && (pending || refresh_due);
                state_n = launch ? REQ : IDLE;
            end
            REQ:       state_n = WAIT_DONE;
            WAIT_DONE: begin
                timeout = !bus.tx_done && cnt == CW'(TLAST);
                state_n = (bus.tx_done || timeout) ? HOLDOFF : WAIT_DONE;
            end
            default:   state_n = cnt == CW'(HLAST) ? IDLE : HOLDOFF;
        endcase
    end

    // state register and shared timeout/hold counter, restarted on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
        end
    end

    // input synchroniser and change detection; changes while busy coalesce into one pending frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            pending <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], bus.cap_in};
            pending <= !launch && (pending || cap_s != last_sent);
        end
    end

    // keep-alive timer: runs only in IDLE, saturates at its last count, restarts on launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ref_cnt <= '0;
        else
            ref_cnt <= launch ? '0 : (state == IDLE && !ref_sat) ? ref_cnt + 1'b1 : ref_cnt;
    end

    // snapshot and payload captured at launch; seq advances as the request cycle ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_sent <= '0;
            tx_data   <= '0;
            seq       <= '0;
        end else begin
            last_sent <= launch ? cap_s : last_sent;
            tx_data   <= launch ? {seq, cap_s} : tx_data;
            seq       <= state == REQ ? seq + 1'b1 : seq;
        end
    end
endmodule
